seg7_pattern_decoder: RTL and testbench

Receiving end of the hex-to-seven-segment path: samples an active-low 7-segment bus, requires each pattern to hold steady for a programmable number of cycles, and decodes it back to a 4-bit hex value. It also flags illegal and blank patterns and keeps saturating match and error counts. It sits on the board-level display bus, where it checks and monitors the hex-to-seven-segment encoder that drives the score digits, and on-chip as a loopback checker.

---
 rtl/seg7_pattern_decoder.sv | 166 ++++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// Seven-segment bus receiver: debounces the active-low segment pattern, decodes
// it back to hex, and flags illegal/blank patterns with saturating event counts.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [6:0]           seg,
  input  logic                 clear_counts,
  output logic [3:0]           hex,
  output logic                 hex_valid,
  output logic                 illegal,
  output logic                 blank,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int             SW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]  STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [6:0]     BLANK_PAT = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t               state_q, state_d;
  logic [6:0]           seg_q, seg_d;
  logic [SW-1:0]        stab_cnt_q, stab_cnt_d;
  logic [6:0]           acc_pat_q, acc_pat_d;
  logic                 acc_ok_q, acc_ok_d;
  logic [3:0]           hex_q, hex_d;
  logic                 hex_valid_q, hex_valid_d;
  logic                 illegal_q, illegal_d;
  logic                 blank_q, blank_d;
  logic [CNT_WIDTH-1:0] match_count_q, match_count_d;
  logic [CNT_WIDTH-1:0] error_count_q, error_count_d;

  logic       seg_change, accept, event_new, dec_ok, match_inc, error_inc;
  logic [3:0] dec_val;

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = '0;
    case (seg_q)
      7'h01: dec_val = 4'h0;
      7'h4F: dec_val = 4'h1;
      7'h12: dec_val = 4'h2;
      7'h06: dec_val = 4'h3;
      7'h4C: dec_val = 4'h4;
      7'h24: dec_val = 4'h5;
      7'h20: dec_val = 4'h6;
      7'h0F: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h04: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h60: dec_val = 4'hB;
      7'h31: dec_val = 4'hC;
      7'h42: dec_val = 4'hD;
      7'h30: dec_val = 4'hE;
      7'h38: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    seg_d      = seg;
    seg_change = (seg != seg_q);
    if (seg_change)
      stab_cnt_d = SW'(1);
    else if (stab_cnt_q == STAB_MAX)
      stab_cnt_d = stab_cnt_q;
    else
      stab_cnt_d = stab_cnt_q + SW'(1);

    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:   state_d = SETTLE;
      SETTLE: begin
        if (stab_cnt_q == STAB_MAX) begin
          accept = 1'b1;
          // A change landing on the accept edge must not be lost by parking in HELD
          state_d = seg_change ? SETTLE : HELD;
        end
      end
      HELD:    if (seg_change) state_d = SETTLE;
      default: state_d = IDLE;
    endcase

    event_new = accept && !(acc_ok_q && (seg_q == acc_pat_q));

    acc_pat_d   = acc_pat_q;
    acc_ok_d    = acc_ok_q;
    hex_d       = hex_q;
    hex_valid_d = 1'b0;
    illegal_d   = 1'b0;
    blank_d     = blank_q;
    match_inc   = 1'b0;
    error_inc   = 1'b0;
    if (event_new) begin
      acc_pat_d = seg_q;
      acc_ok_d  = 1'b1;
      if (dec_ok) begin
        hex_d       = dec_val;
        hex_valid_d = 1'b1;
        blank_d     = 1'b0;
        match_inc   = 1'b1;
      end else if (seg_q == BLANK_PAT) begin
        blank_d = 1'b1;
      end else begin
        illegal_d = 1'b1;
        blank_d   = 1'b0;
        error_inc = 1'b1;
      end
    end

    if (clear_counts)
      match_count_d = '0;
    else if (match_inc && (match_count_q != '1))
      match_count_d = match_count_q + CNT_WIDTH'(1);
    else
      match_count_d = match_count_q;

    if (clear_counts)
      error_count_d = '0;
    else if (error_inc && (error_count_q != '1))
      error_count_d = error_count_q + CNT_WIDTH'(1);
    else
      error_count_d = error_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      seg_q         <= BLANK_PAT;
      stab_cnt_q    <= '0;
      acc_pat_q     <= '0;
      acc_ok_q      <= 1'b0;
      hex_q         <= '0;
      hex_valid_q   <= 1'b0;
      illegal_q     <= 1'b0;
      blank_q       <= 1'b0;
      match_count_q <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      stab_cnt_q    <= stab_cnt_d;
      acc_pat_q     <= acc_pat_d;
      acc_ok_q      <= acc_ok_d;
      hex_q         <= hex_d;
      hex_valid_q   <= hex_valid_d;
      illegal_q     <= illegal_d;
      blank_q       <= blank_d;
      match_count_q <= match_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign hex         = hex_q;
  assign hex_valid   = hex_valid_q;
  assign illegal     = illegal_q;
  assign blank       = blank_q;
  assign match_count = match_count_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed bench for seg7_pattern_decoder: three instances cover the default
// configuration, a 2-bit counter build, and single-cycle stability.
module tb_seg7_pattern_decoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, clr_a, hv_a, il_a, bl_a;
  logic [6:0] seg_a;
  logic [3:0] hex_a;
  logic [7:0] mc_a, ec_a;

  logic       rst_b, clr_b, hv_b, il_b, bl_b;
  logic [6:0] seg_b;
  logic [3:0] hex_b;
  logic [1:0] mc_b, ec_b;

  logic       rst_c, clr_c, hv_c, il_c, bl_c;
  logic [6:0] seg_c;
  logic [3:0] hex_c;
  logic [7:0] mc_c, ec_c;

  seg7_pattern_decoder #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) u_a (
    .clock(clock), .reset(rst_a), .seg(seg_a), .clear_counts(clr_a),
    .hex(hex_a), .hex_valid(hv_a), .illegal(il_a), .blank(bl_a),
    .match_count(mc_a), .error_count(ec_a));

  seg7_pattern_decoder #(.STABLE_CYCLES(4), .CNT_WIDTH(2)) u_b (
    .clock(clock), .reset(rst_b), .seg(seg_b), .clear_counts(clr_b),
    .hex(hex_b), .hex_valid(hv_b), .illegal(il_b), .blank(bl_b),
    .match_count(mc_b), .error_count(ec_b));

  seg7_pattern_decoder #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) u_c (
    .clock(clock), .reset(rst_c), .seg(seg_c), .clear_counts(clr_c),
    .hex(hex_c), .hex_valid(hv_c), .illegal(il_c), .blank(bl_c),
    .match_count(mc_c), .error_count(ec_c));

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] codes [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one pattern on instance A for n edges and records where pulses fell.
  task automatic drive_a(input logic [6:0] code, input int n,
                         output int v_edge, output int i_edge,
                         output int v_cnt, output int i_cnt);
    v_edge = 0; i_edge = 0; v_cnt = 0; i_cnt = 0;
    @(negedge clock);
    seg_a = code;
    for (int e = 1; e <= n; e++) begin
      step();
      if (hv_a === 1'b1) begin v_cnt++; v_edge = e; end
      if (il_a === 1'b1) begin i_cnt++; i_edge = e; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ve, ie, vc, ic;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    seg_a = 7'h7F; seg_b = 7'h7F; seg_c = 7'h7F;
    step(); step();

    check("rst_hex", hex_a, 0);
    check("rst_hv",  hv_a,  0);
    check("rst_il",  il_a,  0);
    check("rst_bl",  bl_a,  0);
    check("rst_mc",  mc_a,  0);
    check("rst_ec",  ec_a,  0);

    // Encoder loopback over all 16 legal codes.
    @(negedge clock);
    rst_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_a(codes[i], 6, ve, ie, vc, ic);
      check("lb_pulses", vc, 1);
      check("lb_edge",   ve, 5);
      check("lb_hex",    hex_a, i);
      check("lb_ill",    ic, 0);
    end
    check("lb_mc", mc_a, 16);
    check("lb_ec", ec_a, 0);

    // Glitch rejection.
    drive_a(7'h24, 6, ve, ie, vc, ic);
    check("gl_first", vc, 1);
    check("gl_hex1",  hex_a, 5);
    drive_a(7'h4F, 2, ve, ie, vc, ic);
    check("gl_glitch", vc, 0);
    drive_a(7'h24, 8, ve, ie, vc, ic);
    check("gl_return", vc, 0);
    check("gl_hex2",   hex_a, 5);
    check("gl_mc",     mc_a, 17);

    // Illegal, blank, then legal.
    drive_a(7'h7E, 6, ve, ie, vc, ic);
    check("il_pulses", ic, 1);
    check("il_edge",   ie, 5);
    check("il_hv",     vc, 0);
    check("il_hex",    hex_a, 5);
    check("il_ec",     ec_a, 1);
    check("il_bl",     bl_a, 0);
    drive_a(7'h7F, 6, ve, ie, vc, ic);
    check("bk_bl",  bl_a, 1);
    check("bk_hv",  vc, 0);
    check("bk_il",  ic, 0);
    check("bk_hex", hex_a, 5);
    check("bk_ec",  ec_a, 1);
    drive_a(7'h06, 6, ve, ie, vc, ic);
    check("lg_pulses", vc, 1);
    check("lg_edge",   ve, 5);
    check("lg_hex",    hex_a, 3);
    check("lg_bl",     bl_a, 0);
    check("lg_mc",     mc_a, 18);
    drive_a(7'h24, 6, ve, ie, vc, ic);
    check("rv_pulses", vc, 1);
    check("rv_hex",    hex_a, 5);

    // Reset mid-settle.
    drive_a(7'h08, 2, ve, ie, vc, ic);
    check("ms_pre", vc, 0);
    @(negedge clock);
    rst_a = 1'b1;
    step();
    check("ms_hex", hex_a, 0);
    check("ms_hv",  hv_a,  0);
    check("ms_il",  il_a,  0);
    check("ms_bl",  bl_a,  0);
    check("ms_mc",  mc_a,  0);
    check("ms_ec",  ec_a,  0);
    @(negedge clock);
    rst_a = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("ms_hv_edge", hv_a, (e == 5));
      if (e == 5) begin
        check("ms_hex_a", hex_a, 10);
        check("ms_mc_a",  mc_a,  1);
      end
    end

    // Saturation and clear with a 2-bit counter.
    @(negedge clock);
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      seg_b = (k % 2 == 0) ? 7'h01 : 7'h4F;
      for (int e = 0; e < 6; e++) step();
      check("sat_hex", hex_b, k % 2);
      check("sat_mc",  mc_b, (k + 1 > 3) ? 3 : k + 1);
    end
    @(negedge clock);
    seg_b = 7'h01;
    for (int e = 0; e < 4; e++) step();
    check("clr_pre", mc_b, 3);
    @(negedge clock);
    clr_b = 1'b1;
    step();
    check("clr_hv", hv_b, 1);
    check("clr_mc", mc_b, 0);
    @(negedge clock);
    clr_b = 1'b0;
    step();
    check("clr_hold", mc_b, 0);
    check("clr_ec",   ec_b, 0);

    // Single-cycle stability.
    @(negedge clock);
    rst_c = 1'b0;
    step(); step(); step();
    check("c_blank", bl_c, 1);
    @(negedge clock); seg_c = 7'h01; step();
    check("c_hv0", hv_c, 0);
    @(negedge clock); seg_c = 7'h4F; step();
    check("c_hv1", hv_c, 1);
    check("c_hx1", hex_c, 0);
    check("c_bl1", bl_c, 0);
    @(negedge clock); seg_c = 7'h12; step();
    check("c_hv2", hv_c, 1);
    check("c_hx2", hex_c, 1);
    step();
    check("c_hv3", hv_c, 1);
    check("c_hx3", hex_c, 2);
    step();
    check("c_hv4", hv_c, 0);
    check("c_mc",  mc_c, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
